// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack sequencer states/ops, interrupt vector default,
// and {C,N,Z} flag bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_FLG,
    ST_POP_FLG,
    ST_POP_PCL,
    ST_POP_PCH,
    ST_VEC_H,
    ST_VEC_L,
    ST_LOAD
  } stack_seq_state_t;

  typedef enum logic [1:0] {
    OP_CALL,
    OP_RET,
    OP_RTI,
    OP_INT
  } stack_seq_op_t;

  localparam int unsigned INT_VEC_ADDR_DFLT = 0;

  localparam int FLAGS_W = 3;
  localparam int FLAG_Z  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 2;

endpackage

// File: rtl/stack_sequencer.sv
// CALL/RET/RTI/interrupt-entry stack sequencer; owns the data-memory port while busy.
// Define STACK_SEQ_FLAGS_SAVE_EN to push flags on interrupt entry and pop them on RTI.
module stack_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W         = 32,
  parameter int unsigned      DATA_W       = 16,
  parameter logic [PC_W-1:0]  INT_VEC_ADDR = PC_W'(INT_VEC_ADDR_DFLT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                call,
  input  logic                ret,
  input  logic                rti,
  input  logic                int_req,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [PC_W-1:0]     target_in,
  input  logic [FLAGS_W-1:0]  flags_in,
  input  logic [PC_W-1:0]     sp_in,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [PC_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                sp_we,
  output logic [PC_W-1:0]     sp_next,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_out,
  output logic                flags_load,
  output logic [FLAGS_W-1:0]  flags_out,
  output logic                int_ack
);

  localparam logic [PC_W-1:0] ONE = PC_W'(1);

`ifdef STACK_SEQ_FLAGS_SAVE_EN
  localparam stack_seq_state_t RTI_FIRST    = ST_POP_FLG;
  localparam stack_seq_state_t INT_AFTER_PC = ST_PUSH_FLG;
  localparam bit               FLAGS_SAVE   = 1'b1;
`else
  localparam stack_seq_state_t RTI_FIRST    = ST_POP_PCL;
  localparam stack_seq_state_t INT_AFTER_PC = ST_VEC_H;
  localparam bit               FLAGS_SAVE   = 1'b0;
`endif

  stack_seq_state_t    state_q, state_d;
  stack_seq_op_t       op_q, op_d;
  logic                int_pending_q, int_pending_d;
  logic [PC_W-1:0]     ret_pc_q, ret_pc_d;
  logic [PC_W-1:0]     tgt_q, tgt_d;
  logic [PC_W-1:0]     sp_cur_q, sp_cur_d;
  logic [FLAGS_W-1:0]  flags_q, flags_d;

  logic                step_req, step_we, step_vec, step_done;
  logic [PC_W-1:0]     step_addr, step_sp;
  logic [DATA_W-1:0]   step_wdata;
  logic                start_int;

  // Memory step handshake: address/data are a pure function of state, so they
  // hold steady through mem_ready=0 cycles.
  always_comb begin : mem_step
    step_req   = 1'b0;
    step_we    = 1'b0;
    step_vec   = 1'b0;
    step_addr  = '0;
    step_wdata = '0;
    step_sp    = sp_cur_q;
    case (state_q)
      ST_PUSH_PCH: begin
        step_req   = 1'b1;
        step_we    = 1'b1;
        step_addr  = sp_cur_q;
        step_wdata = ret_pc_q[PC_W-1:DATA_W];
        step_sp    = sp_cur_q - ONE;
      end
      ST_PUSH_PCL: begin
        step_req   = 1'b1;
        step_we    = 1'b1;
        step_addr  = sp_cur_q;
        step_wdata = ret_pc_q[DATA_W-1:0];
        step_sp    = sp_cur_q - ONE;
      end
      ST_PUSH_FLG: begin
        step_req   = 1'b1;
        step_we    = 1'b1;
        step_addr  = sp_cur_q;
        step_wdata = {{(DATA_W-FLAGS_W){1'b0}}, flags_q};
        step_sp    = sp_cur_q - ONE;
      end
      ST_POP_FLG, ST_POP_PCL, ST_POP_PCH: begin
        step_req   = 1'b1;
        step_addr  = sp_cur_q + ONE;
        step_sp    = sp_cur_q + ONE;
      end
      ST_VEC_H: begin
        step_req   = 1'b1;
        step_vec   = 1'b1;
        step_addr  = INT_VEC_ADDR;
      end
      ST_VEC_L: begin
        step_req   = 1'b1;
        step_vec   = 1'b1;
        step_addr  = INT_VEC_ADDR + ONE;
      end
      default: ;
    endcase
    step_done = step_req & mem_ready;
  end

  always_comb begin : seq_next
    state_d   = state_q;
    op_d      = op_q;
    ret_pc_d  = ret_pc_q;
    tgt_d     = tgt_q;
    sp_cur_d  = sp_cur_q;
    flags_d   = flags_q;
    start_int = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_pending_q || rti || ret || call) begin
          ret_pc_d = pc_in;
          tgt_d    = target_in;
          sp_cur_d = sp_in;
          flags_d  = flags_in;
        end
        if (int_pending_q) begin
          start_int = 1'b1;
          op_d      = OP_INT;
          state_d   = ST_PUSH_PCH;
        end else if (rti) begin
          op_d    = OP_RTI;
          state_d = RTI_FIRST;
        end else if (ret) begin
          op_d    = OP_RET;
          state_d = ST_POP_PCL;
        end else if (call) begin
          op_d    = OP_CALL;
          state_d = ST_PUSH_PCH;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: begin
        if (step_done) begin
          if (!step_vec) sp_cur_d = step_sp;
          case (state_q)
            ST_PUSH_PCH: state_d = ST_PUSH_PCL;
            ST_PUSH_PCL: state_d = (op_q == OP_INT) ? INT_AFTER_PC : ST_LOAD;
            ST_PUSH_FLG: state_d = ST_VEC_H;
            ST_POP_FLG: begin
              flags_d = mem_rdata[FLAGS_W-1:0];
              state_d = ST_POP_PCL;
            end
            ST_POP_PCL: begin
              tgt_d[DATA_W-1:0] = mem_rdata;
              state_d           = ST_POP_PCH;
            end
            ST_POP_PCH: begin
              tgt_d[PC_W-1:DATA_W] = mem_rdata;
              state_d              = ST_LOAD;
            end
            ST_VEC_H: begin
              tgt_d[PC_W-1:DATA_W] = mem_rdata;
              state_d              = ST_VEC_L;
            end
            ST_VEC_L: begin
              tgt_d[DATA_W-1:0] = mem_rdata;
              state_d           = ST_LOAD;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
    // A request landing in the same cycle the previous one is taken stays pending.
    int_pending_d = int_req | (int_pending_q & ~start_int);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_CALL;
      int_pending_q <= 1'b0;
      ret_pc_q      <= '0;
      tgt_q         <= '0;
      sp_cur_q      <= '0;
      flags_q       <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      int_pending_q <= int_pending_d;
      ret_pc_q      <= ret_pc_d;
      tgt_q         <= tgt_d;
      sp_cur_q      <= sp_cur_d;
      flags_q       <= flags_d;
    end
  end

  // Outputs are gated by reset so an aborted sequence emits no strobes.
  always_comb begin : outputs
    busy       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    sp_we      = 1'b0;
    sp_next    = '0;
    pc_load    = 1'b0;
    pc_out     = '0;
    flags_load = 1'b0;
    flags_out  = '0;
    int_ack    = 1'b0;
    if (!reset) begin
      busy       = (state_q != ST_IDLE);
      mem_req    = step_req;
      mem_we     = step_we;
      mem_addr   = step_addr;
      mem_wdata  = step_wdata;
      sp_we      = step_done & ~step_vec;
      sp_next    = sp_we ? step_sp : '0;
      pc_load    = (state_q == ST_LOAD);
      pc_out     = pc_load ? tgt_q : '0;
      flags_load = FLAGS_SAVE && pc_load && (op_q == OP_RTI);
      flags_out  = flags_load ? flags_q : '0;
      int_ack    = (state_q == ST_IDLE) && int_pending_q;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: step-list reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stack_sequencer;

`ifdef STACK_SEQ_FLAGS_SAVE_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif
  localparam logic [31:0] VEC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        call = 1'b0, ret = 1'b0, rti = 1'b0, int_req = 1'b0;
  logic [31:0] pc_in = '0, target_in = '0, sp_in = '0;
  logic [2:0]  flags_in = '0;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_rdata;
  logic        busy, mem_req, mem_we, sp_we, pc_load, flags_load, int_ack;
  logic [31:0] mem_addr, sp_next, pc_out;
  logic [15:0] mem_wdata;
  logic [2:0]  flags_out;

  always #5 clk = ~clk;

  stack_sequencer #(.PC_W(32), .DATA_W(16), .INT_VEC_ADDR(VEC)) dut (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .rti(rti), .int_req(int_req),
    .pc_in(pc_in), .target_in(target_in), .flags_in(flags_in), .sp_in(sp_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_we(sp_we),
    .sp_next(sp_next), .pc_load(pc_load), .pc_out(pc_out), .flags_load(flags_load),
    .flags_out(flags_out), .int_ack(int_ack)
  );

  logic [15:0] mem [0:4095];
  bit          mem_init = 1'b0;
  assign mem_rdata = mem[mem_addr[11:0]];

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a start expands into a list of memory steps, then one LOAD cycle.
  typedef struct {
    bit          we;
    bit          vec;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [31:0] sp_after;
    int          dest;    // 1 pc hi, 2 pc lo, 3 flags
  } step_t;

  step_t       m_steps[$];
  step_t       cur;
  bit          m_load = 0, m_pend = 0, m_call = 0, m_rti = 0, start_int;
  logic [31:0] m_target = '0;
  logic [15:0] m_hi = '0, m_lo = '0;
  logic [2:0]  m_flg = '0;

  function automatic step_t mk(bit we, bit vec, logic [31:0] addr, logic [15:0] wd,
                               logic [31:0] spa, int dest);
    step_t s;
    s.we = we; s.vec = vec; s.addr = addr; s.wdata = wd; s.sp_after = spa; s.dest = dest;
    return s;
  endfunction

  task automatic m_start(input int kind);  // 0 call, 1 ret, 2 rti, 3 int
    logic [31:0] sp;
    int k;
    sp = sp_in;
    k = 1;
    m_call = (kind == 0);
    m_rti = (kind == 2);
    m_target = target_in;
    m_flg = flags_in;
    if (kind == 0 || kind == 3) begin
      m_steps.push_back(mk(1, 0, sp, pc_in[31:16], sp - 1, 0));
      m_steps.push_back(mk(1, 0, sp - 1, pc_in[15:0], sp - 2, 0));
      if (kind == 3) begin
        if (FS) m_steps.push_back(mk(1, 0, sp - 2, {13'b0, flags_in}, sp - 3, 0));
        m_steps.push_back(mk(0, 1, VEC, 16'h0, 32'h0, 1));
        m_steps.push_back(mk(0, 1, VEC + 1, 16'h0, 32'h0, 2));
      end
    end else begin
      if (kind == 2 && FS) begin
        m_steps.push_back(mk(0, 0, sp + 1, 16'h0, sp + 1, 3));
        k = 2;
      end
      m_steps.push_back(mk(0, 0, sp + k, 16'h0, sp + k, 2));
      m_steps.push_back(mk(0, 0, sp + k + 1, 16'h0, sp + k + 1, 1));
    end
  endtask

  logic        e_busy, e_req, e_we, e_sp_we, e_pc_load, e_flags_load, e_int_ack;
  logic [31:0] e_addr, e_sp_next, e_pc_out;
  logic [15:0] e_wdata;
  logic [2:0]  e_flags_out;
  int          last_pc_load_cyc = -1, last_flags_load_cyc = -1, last_int_ack_cyc = -1;
  logic [31:0] last_pc_out = '0, last_sp_next = '0;
  logic [2:0]  last_flags_out = '0;
  int          cnt_pc_load = 0, cnt_sp_we = 0;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
      mem[1] = 16'h0100;
      mem_init = 1'b1;
    end
    e_busy = 0; e_req = 0; e_we = 0; e_sp_we = 0; e_pc_load = 0; e_flags_load = 0;
    e_int_ack = 0; e_addr = '0; e_sp_next = '0; e_pc_out = '0; e_wdata = '0; e_flags_out = '0;
    if (!reset) begin
      if (m_load) begin
        e_busy = 1; e_pc_load = 1;
        e_pc_out = m_call ? m_target : {m_hi, m_lo};
        if (FS && m_rti) begin e_flags_load = 1; e_flags_out = m_flg; end
      end else if (m_steps.size() != 0) begin
        cur = m_steps[0];
        e_busy = 1; e_req = 1; e_we = cur.we; e_addr = cur.addr; e_wdata = cur.wdata;
        if (mem_ready && !cur.vec) begin e_sp_we = 1; e_sp_next = cur.sp_after; end
      end else begin
        e_int_ack = m_pend;
      end
    end
    chk("busy", busy, e_busy);
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("sp_we", sp_we, e_sp_we);
    chk("sp_next", sp_next, e_sp_next);
    chk("pc_load", pc_load, e_pc_load);
    chk("pc_out", pc_out, e_pc_out);
    chk("flags_load", flags_load, e_flags_load);
    chk("flags_out", flags_out, e_flags_out);
    chk("int_ack", int_ack, e_int_ack);
    if (pc_load) begin last_pc_load_cyc = cyc; last_pc_out = pc_out; cnt_pc_load++; end
    if (flags_load) begin last_flags_load_cyc = cyc; last_flags_out = flags_out; end
    if (int_ack) last_int_ack_cyc = cyc;
    if (sp_we) begin last_sp_next = sp_next; cnt_sp_we++; end
    if (reset) begin
      m_steps.delete(); m_load = 0; m_pend = 0;
    end else begin
      start_int = 0;
      if (m_load) m_load = 0;
      else if (m_steps.size() != 0) begin
        if (mem_ready) begin
          cur = m_steps.pop_front();
          if (cur.we) mem[cur.addr[11:0]] = cur.wdata;
          else case (cur.dest)
            1: m_hi = mem[cur.addr[11:0]];
            2: m_lo = mem[cur.addr[11:0]];
            3: m_flg = mem[cur.addr[11:0]][2:0];
            default: ;
          endcase
          if (m_steps.size() == 0) m_load = 1;
        end
      end else begin
        if (m_pend) begin m_start(3); start_int = 1; end
        else if (rti) m_start(2);
        else if (ret) m_start(1);
        else if (call) m_start(0);
      end
      m_pend = int_req | (m_pend & !start_int);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int idle_cnt, k;
    idle_cnt = 0; k = 0;
    while (idle_cnt < 2 && k < 100) begin
      tick(); k++;
      if (!busy && !int_ack) idle_cnt++; else idle_cnt = 0;
    end
    if (idle_cnt < 2) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout busy=%0b", busy);
    end
  endtask

  task automatic start_op(input int kind, output int n);
    tick(); n = cyc;
    case (kind)
      0: call = 1;
      1: ret = 1;
      default: rti = 1;
    endcase
    tick(); call = 0; ret = 0; rti = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c_pl, c_sw;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_int_ack", int_ack, 0);
    chk("rst_mem_req", mem_req, 0);

    // CALL pushes return PC at the top of a 1M-word stack
    sp_in = 32'h000FFFFF; pc_in = 32'h00010020; target_in = 32'h40; mem_ready = 1;
    start_op(0, n); wait_idle();
    chk("call_load_cyc", last_pc_load_cyc, n + 3);
    chk("call_pc_out", last_pc_out, 32'h40);
    chk("call_m_hi", mem[12'hFFF], 16'h0001);
    chk("call_m_lo", mem[12'hFFE], 16'h0020);
    chk("call_sp_end", last_sp_next, 32'h000FFFFD);

    sp_in = 32'h000FFFFD; pc_in = 32'h0;
    start_op(1, n); wait_idle();
    chk("ret_load_cyc", last_pc_load_cyc, n + 3);
    chk("ret_pc_out", last_pc_out, 32'h00010020);
    chk("ret_sp_end", last_sp_next, 32'h000FFFFF);

    // interrupt entry through vector at words 0/1
    sp_in = 32'h000FFFFF; pc_in = 32'h00012345; flags_in = 3'b101;
    tick(); int_req = 1; n = cyc + 1;
    tick(); int_req = 0;
    wait_idle();
    chk("int_ack_cyc", last_int_ack_cyc, n);
    chk("int_load_cyc", last_pc_load_cyc, FS ? n + 6 : n + 5);
    chk("int_pc_out", last_pc_out, 32'h00000100);
    chk("int_m_hi", mem[12'hFFF], 16'h0001);
    chk("int_m_lo", mem[12'hFFE], 16'h2345);
    if (FS) chk("int_m_flg", mem[12'hFFD], 16'h0005);

    sp_in = FS ? 32'h000FFFFC : 32'h000FFFFD; flags_in = 3'b000;
    start_op(2, n); wait_idle();
    chk("rti_load_cyc", last_pc_load_cyc, FS ? n + 4 : n + 3);
    chk("rti_pc_out", last_pc_out, 32'h00012345);
    chk("rti_sp_end", last_sp_next, 32'h000FFFFF);
    if (FS) begin
      chk("rti_flags_cyc", last_flags_load_cyc, n + 4);
      chk("rti_flags_out", last_flags_out, 3'b101);
    end else begin
      chk("rti_no_flags", last_flags_load_cyc, -1);
    end

    // CALL stalled two cycles on PUSH_PCL with an interrupt queued behind it
    sp_in = 32'h200; pc_in = 32'h11112222; target_in = 32'h3000;
    tick(); n = cyc; call = 1; mem_ready = 1;
    tick(); call = 0; int_req = 1;
    tick(); int_req = 0; mem_ready = 0;
    tick();
    chk("stall_addr", mem_addr, 32'h1FF);
    chk("stall_wdata", mem_wdata, 16'h2222);
    tick(); mem_ready = 1;
    chk("stall_no_load", pc_load, 0);
    tick();
    chk("stall_pc_load", pc_load, 1);
    chk("stall_pc_out", pc_out, 32'h3000);
    tick();
    chk("stall_idle_gap", busy, 0);
    chk("stall_int_ack", int_ack, 1);
    tick();
    chk("stall_int_busy", busy, 1);
    wait_idle();

    // reset during PUSH_PCL aborts the CALL
    sp_in = 32'h300; pc_in = 32'h5555AAAA; target_in = 32'h77;
    start_op(0, n);
    tick(); reset = 1;
    tick(); reset = 0;
    chk("abort_busy", busy, 0);
    c_pl = cnt_pc_load; c_sw = cnt_sp_we;
    repeat (5) tick();
    chk("abort_no_pc_load", cnt_pc_load, c_pl);
    chk("abort_no_sp_we", cnt_sp_we, c_sw);
    start_op(0, n); wait_idle();
    chk("recall_load_cyc", last_pc_load_cyc, n + 3);
    chk("recall_pc_out", last_pc_out, 32'h77);
    chk("recall_sp_end", last_sp_next, 32'h2FE);

    for (int i = 0; i < 2500; i++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      call = ($urandom_range(0, 5) == 0);
      ret = ($urandom_range(0, 5) == 0);
      rti = ($urandom_range(0, 5) == 0);
      int_req = ($urandom_range(0, 29) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: sp_in = 32'h0;
        1: sp_in = 32'hFFFFFFFF;
        default: sp_in = $urandom;
      endcase
      pc_in = $urandom;
      target_in = $urandom;
      flags_in = 3'($urandom);
    end
    tick();
    reset = 0; call = 0; ret = 0; rti = 0; int_req = 0; mem_ready = 1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
